boot_mem_responder: RTL
=======================

Name: boot_mem_responder

Overview:
- Memory-side responder for the 6502 core's read bus.
- The core drives a registered 16-bit `address`; this block returns `rd_data` combinationally from that address in the same cycle. This matches the core's VECTOR/FETCH/DECODE timing.
- It contains a byte RAM, the reset-vector registers at FFFC/FFFD, and a byte-serial loader FSM.
- The loader fills RAM and the vector, then releases the core from reset.

Parameters:
- RAM_AW, 11, RAM address width; RAM occupies 0x0000 to 2^RAM_AW-1.
- FILL_BYTE, 8'hEA, returned for unmapped reads (NOP).
- RESET_VEC, 16'h0000, reset value of the vector registers.
- LOAD_ON_RESET, 1, 1 = enter the load state after reset; 0 = enter RUN.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- address  in  16  core address bus
- rd_data  out  8  read data, combinational from address
- ld_start  in  1  single-cycle pulse; (re)starts a load frame
- ld_valid  in  1  loader byte valid
- ld_data  in  8  loader byte
- ld_ready  out  1  loader byte accepted when ld_valid && ld_ready
- cpu_resetn  out  1  registered reset to the core; low while loading
- ld_err  out  1  sticky; a data byte targeted an address outside RAM
- busy  out  1  high in any state other than RUN

Behaviour:
- Clock, reset and reset values
  - One clock (clk). Reset (resetn) is asynchronous and active-low.
  - Reset values: state = ADDR_LO if LOAD_ON_RESET else RUN; cpu_resetn = 0; ld_err = 0; vector = RESET_VEC; ptr = 0; len = 0.
  - RAM contents are not reset.
- Read path, zero latency
  - address < 2^RAM_AW: rd_data = ram[address].
  - address = 16'hFFFC: rd_data = vec[7:0].
  - address = 16'hFFFD: rd_data = vec[15:8].
  - Any other address: rd_data = FILL_BYTE.
  - The read path is active in all states, including during loading.
- Frame format: addr_lo, addr_hi, len_lo, len_hi, len data bytes, vec_lo, vec_hi.
- FSM states: ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, VEC_LO, VEC_HI, RUN (one-hot).
  - A byte is accepted only on a cycle with ld_valid && ld_ready.
  - ld_ready = 1 in every state except RUN.
  - ADDR_LO/ADDR_HI: capture ptr[7:0] / ptr[15:8].
  - LEN_LO: capture len[7:0].
  - LEN_HI: capture len[15:8]. Next state is DATA if the full 16-bit len != 0, else VEC_LO.
- DATA state
  - Each accepted byte is written to ram[ptr] when ptr < 2^RAM_AW. Otherwise the byte is dropped and ld_err is set.
  - ptr increments modulo 2^16 (FFFF wraps to 0000); len decrements.
  - On the byte that takes len from 1 to 0, go to VEC_LO.
- VEC_LO/VEC_HI: capture vec[7:0] / vec[15:8]. After VEC_HI is accepted, go to RUN.
- cpu_resetn
  - Registered: equals 1 exactly when state == RUN, delayed one cycle.
  - It therefore rises on the cycle after entry to RUN. The core then reads FFFC/FFFD with the new vector already valid.
- ld_start
  - Takes effect from any state: next state = ADDR_LO and cpu_resetn drops on the next edge.
  - A byte presented on the same cycle as ld_start is not accepted (ld_ready is forced 0 on that cycle).
  - Partial RAM writes from an aborted frame are kept.
  - ld_err clears on ld_start.
- Write/read collision: a RAM write and a read of the same address in the same cycle return the old data. The new data is visible the next cycle.
- resetn asserted mid-frame: FSM, vector and ld_err return to reset values immediately (asynchronously). RAM contents persist.
- Out-of-range handling: the vector registers are not writable through DATA bytes. FFFC/FFFD in the data stream count as out of RAM, are dropped and set ld_err.

Decomposition:
- Package mem_map_pkg holds:
  - RESET_LSB_ADDR = 16'hFFFC and RESET_MSB_ADDR = 16'hFFFD;
  - the FSM state indices and the EMPTY one-hot constant;
  - the default FILL_BYTE.
- One sub-module, ram_async_1w1r: byte-wide, depth 2^RAM_AW, synchronous write, asynchronous read. It is instanced once.
- The FSM, vector registers and read mux stay in boot_mem_responder.

Test Plan:
- Reset with LOAD_ON_RESET=1, no load; read address FFFC/FFFD/0x9000 -> rd_data 00/00/EA; cpu_resetn=0, busy=1, ld_ready=1.
- Frame 00,02,03,00,A9,55,EA,00,02 -> ram[0200..0202]=A9,55,EA; vec=0200; cpu_resetn rises one cycle after VEC_HI is accepted; reads of FFFC/FFFD return 00/02.
- Frame with len=0: 00,00,00,00,34,12 -> no RAM write; vec=1234; RUN reached after 6 accepted bytes.
- Frame with ptr=07FF, len=2, data 11,22 -> ram[07FF]=11; second byte dropped; ld_err=1; ld_err clears on the next ld_start.
- ld_start pulsed while ld_valid=1 in DATA after 1 of 3 bytes -> that byte not accepted; state ADDR_LO; first byte remains in RAM; cpu_resetn stays 0.
- resetn asserted mid-DATA, then released -> state ADDR_LO, vec=RESET_VEC; previously written RAM bytes still readable.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared address map, state encoding and defaults for the boot memory responder.
package mem_map_pkg;

   localparam logic [15:0] RESET_LSB_ADDR    = 16'hFFFC;
   localparam logic [15:0] RESET_MSB_ADDR    = 16'hFFFD;
   localparam logic [7:0]  DEFAULT_FILL_BYTE = 8'hEA;

   localparam int S_ADDR_LO  = 0;
   localparam int S_ADDR_HI  = 1;
   localparam int S_LEN_LO   = 2;
   localparam int S_LEN_HI   = 3;
   localparam int S_DATA     = 4;
   localparam int S_VEC_LO   = 5;
   localparam int S_VEC_HI   = 6;
   localparam int S_RUN      = 7;
   localparam int NUM_STATES = 8;

   localparam logic [NUM_STATES-1:0] EMPTY = '0;

   typedef enum logic [NUM_STATES-1:0] {
      ST_ADDR_LO = 8'(1 << S_ADDR_LO),
      ST_ADDR_HI = 8'(1 << S_ADDR_HI),
      ST_LEN_LO  = 8'(1 << S_LEN_LO),
      ST_LEN_HI  = 8'(1 << S_LEN_HI),
      ST_DATA    = 8'(1 << S_DATA),
      ST_VEC_LO  = 8'(1 << S_VEC_LO),
      ST_VEC_HI  = 8'(1 << S_VEC_HI),
      ST_RUN     = 8'(1 << S_RUN)
   } state_e;

endpackage

// File: rtl/ram_async_1w1r.sv
// Byte-wide RAM: synchronous write, asynchronous read; a same-cycle read sees the old byte.
module ram_async_1w1r #(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [0:(1 << AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/boot_mem_responder.sv
// Read-bus responder for the 6502 core: byte RAM, reset vector and a byte-serial loader
// that fills both, then releases the core from reset.
//
// state   | meaning
// ADDR_LO | waiting for load pointer low byte
// ADDR_HI | waiting for load pointer high byte
// LEN_LO  | waiting for data length low byte
// LEN_HI  | waiting for data length high byte
// DATA    | writing len bytes starting at ptr
// VEC_LO  | waiting for reset vector low byte
// VEC_HI  | waiting for reset vector high byte
// RUN     | load complete, core released
module boot_mem_responder
   import mem_map_pkg::*;
#(
   parameter int          RAM_AW        = 11,
   parameter logic [7:0]  FILL_BYTE     = DEFAULT_FILL_BYTE,
   parameter logic [15:0] RESET_VEC     = 16'h0000,
   parameter bit          LOAD_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] address,
   output logic [7:0]  rd_data,
   input  logic        ld_start,
   input  logic        ld_valid,
   input  logic [7:0]  ld_data,
   output logic        ld_ready,
   output logic        cpu_resetn,
   output logic        ld_err,
   output logic        busy
);

   localparam state_e RESET_STATE = LOAD_ON_RESET ? ST_ADDR_LO : ST_RUN;

   state_e      state_q, state_d;
   logic [15:0] ptr_q, ptr_d;
   logic [15:0] len_q, len_d;
   logic [15:0] vec_q, vec_d;
   logic        ld_err_q, ld_err_d;
   logic        cpu_resetn_q, cpu_resetn_d;

   logic        accept;
   logic        ptr_in_ram;
   logic        ram_we;
   logic [7:0]  ram_rdata;
   logic [15:0] len_new;

   assign ptr_in_ram = (ptr_q[15:RAM_AW] == '0);
   assign len_new    = {ld_data, len_q[7:0]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= RESET_STATE;
         ptr_q        <= '0;
         len_q        <= '0;
         vec_q        <= RESET_VEC;
         ld_err_q     <= 1'b0;
         cpu_resetn_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         len_q        <= len_d;
         vec_q        <= vec_d;
         ld_err_q     <= ld_err_d;
         cpu_resetn_q <= cpu_resetn_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      len_d        = len_q;
      vec_d        = vec_q;
      ld_err_d     = ld_err_q;
      ram_we       = 1'b0;
      // ld_start wins over any byte offered in the same cycle
      ld_ready     = (state_q != ST_RUN) && !ld_start;
      accept       = ld_valid && ld_ready;
      cpu_resetn_d = (state_q == ST_RUN) && !ld_start;

      if (ld_start) begin
         state_d  = ST_ADDR_LO;
         ld_err_d = 1'b0;
      end else if (accept) begin
         case (state_q)
            ST_ADDR_LO: begin
               ptr_d[7:0] = ld_data;
               state_d    = ST_ADDR_HI;
            end
            ST_ADDR_HI: begin
               ptr_d[15:8] = ld_data;
               state_d     = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               len_d[7:0] = ld_data;
               state_d    = ST_LEN_HI;
            end
            ST_LEN_HI: begin
               len_d   = len_new;
               state_d = (len_new != 16'd0) ? ST_DATA : ST_VEC_LO;
            end
            ST_DATA: begin
               // vector registers are deliberately not reachable from the data stream
               if (ptr_in_ram) ram_we   = 1'b1;
               else            ld_err_d = 1'b1;
               ptr_d = ptr_q + 16'd1;
               len_d = len_q - 16'd1;
               if (len_q == 16'd1) state_d = ST_VEC_LO;
            end
            ST_VEC_LO: begin
               vec_d[7:0] = ld_data;
               state_d    = ST_VEC_HI;
            end
            ST_VEC_HI: begin
               vec_d[15:8] = ld_data;
               state_d     = ST_RUN;
            end
            default: ;
         endcase
      end
   end

   ram_async_1w1r #(
      .AW(RAM_AW)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .waddr(ptr_q[RAM_AW-1:0]),
      .wdata(ld_data),
      .raddr(address[RAM_AW-1:0]),
      .rdata(ram_rdata)
   );

   always_comb begin
      rd_data = FILL_BYTE;
      if (address[15:RAM_AW] == '0)         rd_data = ram_rdata;
      else if (address == RESET_LSB_ADDR)   rd_data = vec_q[7:0];
      else if (address == RESET_MSB_ADDR)   rd_data = vec_q[15:8];
   end

   assign cpu_resetn = cpu_resetn_q;
   assign ld_err     = ld_err_q;
   assign busy       = (state_q != ST_RUN);

endmodule
